// File: rtl/packet_hex_framer.sv
// Serializes one wide correlator packet into an uppercase ASCII-hex byte stream,
// followed by a CRC-16/CCITT-FALSE trailer (over the hex characters) and a terminator byte.
module packet_hex_framer #(
  parameter int unsigned PACKET_SIZE = 256,
  parameter logic [7:0]  TERMINATOR  = 8'h0D
) (
  input  logic                   intclk,
  input  logic                   reset,
  input  logic [PACKET_SIZE-1:0] packet_in,
  input  logic                   packet_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_byte,
  output logic                   tx_strobe,
  output logic                   busy,
  output logic [15:0]            dropped
);

  localparam int unsigned NIBBLES = PACKET_SIZE / 4;
  localparam int unsigned CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CRC, ST_TERM} state_t;

  state_t                 state, state_n;
  logic [PACKET_SIZE-1:0] shreg, shreg_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [15:0]            crc, crc_n, crc_sh;
  logic [1:0]             cidx, cidx_n;
  logic [7:0]             byte_n;
  logic                   strobe_n;
  logic [15:0]            dropped_n;
  logic                   accept;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // Next-state and next-output logic; registered outputs hold unless a byte is accepted.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    crc_n     = crc;
    cidx_n    = cidx;
    byte_n    = tx_byte;
    dropped_n = dropped;
    crc_sh    = 16'h0000;
    accept    = tx_strobe && tx_ready;

    if (packet_valid && (state != ST_IDLE) && (dropped != 16'hFFFF)) begin
      dropped_n = dropped + 16'd1;
    end

    case (state)
      ST_IDLE: begin
        if (packet_valid) begin
          shreg_n = packet_in;
          cnt_n   = '0;
          crc_n   = 16'hFFFF;
          cidx_n  = 2'd0;
          byte_n  = hex(packet_in[PACKET_SIZE-1 -: 4]);
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          crc_n   = crc_step(crc, tx_byte);
          shreg_n = shreg << 4;
          if (cnt == LAST) begin
            cidx_n  = 2'd0;
            byte_n  = hex(crc_n[15:12]);
            state_n = ST_CRC;
          end else begin
            cnt_n  = cnt + CW'(1);
            byte_n = hex(shreg_n[PACKET_SIZE-1 -: 4]);
          end
        end
      end
      ST_CRC: begin
        if (accept) begin
          if (cidx == 2'd3) begin
            byte_n  = TERMINATOR;
            state_n = ST_TERM;
          end else begin
            cidx_n = cidx + 2'd1;
            crc_sh = crc << {cidx_n, 2'b00};
            byte_n = hex(crc_sh[15:12]);
          end
        end
      end
      ST_TERM: begin
        if (accept) begin
          byte_n  = 8'h00;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    strobe_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge intclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      crc       <= 16'hFFFF;
      cidx      <= 2'd0;
      tx_byte   <= 8'h00;
      tx_strobe <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 16'h0000;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      crc       <= crc_n;
      cidx      <= cidx_n;
      tx_byte   <= byte_n;
      tx_strobe <= strobe_n;
      busy      <= strobe_n;
      dropped   <= dropped_n;
    end
  end

endmodule

// File: tb/tb_packet_hex_framer.sv
// Scoreboard bench for packet_hex_framer: 36-bit and 8-bit instances, expected bytes queued
// at load time and popped by per-instance monitors on every accepted byte.
module tb_packet_hex_framer;

  logic        clk = 1'b0;
  logic        reset, ready;
  logic [35:0] pkt36;
  logic [7:0]  pkt8;
  logic        pv36, pv8;
  logic [7:0]  byte36, byte8;
  logic        stb36, stb8, busy36, busy8;
  logic [15:0] drop36, drop8;

  int total = 0;
  int bad   = 0;

  logic [7:0] q36[$];
  logic [7:0] q8[$];
  logic       stall36 = 1'b0, stall8 = 1'b0;
  logic [7:0] held36 = 8'h00, held8 = 8'h00;

  always #5 clk = ~clk;

  packet_hex_framer #(.PACKET_SIZE(36), .TERMINATOR(8'h0D)) dut36 (
    .intclk(clk), .reset(reset), .packet_in(pkt36), .packet_valid(pv36), .tx_ready(ready),
    .tx_byte(byte36), .tx_strobe(stb36), .busy(busy36), .dropped(drop36));

  packet_hex_framer #(.PACKET_SIZE(8), .TERMINATOR(8'h0D)) dut8 (
    .intclk(clk), .reset(reset), .packet_in(pkt8), .packet_valid(pv8), .tx_ready(ready),
    .tx_byte(byte8), .tx_strobe(stb8), .busy(busy8), .dropped(drop8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  // Reference CRC: input bit folded into the feedback bit, one bit at a time.
  function automatic logic [15:0] crc_bits(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic push_b(input bit to8, input logic [7:0] b);
    if (to8) q8.push_back(b);
    else     q36.push_back(b);
  endtask

  task automatic push_frame(input logic [35:0] p, input int nib, input bit to8);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = nib - 1; i >= 0; i--) begin
      b = hx(p[i*4 +: 4]);
      c = crc_bits(c, b);
      push_b(to8, b);
    end
    for (int i = 3; i >= 0; i--) push_b(to8, hx(c[i*4 +: 4]));
    push_b(to8, 8'h0D);
  endtask

  task automatic start36(input logic [35:0] p);
    pkt36 = p;
    pv36  = 1'b1;
    tick();
    pv36  = 1'b0;
  endtask

  // Monitors: pop on every accept, and require a stalled byte to hold its value.
  always @(negedge clk) begin
    if (stb36 && ready) begin
      if (q36.size() == 0) begin
        total++; bad++;
        $display("FAIL out36: got %h expected nothing", byte36);
      end else chk("out36", 32'(byte36), 32'(q36.pop_front()));
    end
    if (stall36 && stb36) chk("stable36", 32'(byte36), 32'(held36));
    stall36 = stb36 && !ready;
    held36  = byte36;
  end

  always @(negedge clk) begin
    if (stb8 && ready) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL out8: got %h expected nothing", byte8);
      end else chk("out8", 32'(byte8), 32'(q8.pop_front()));
    end
    if (stall8 && stb8) chk("stable8", 32'(byte8), 32'(held8));
    stall8 = stb8 && !ready;
    held8  = byte8;
  end

  initial begin
    logic [7:0] exp1 [14];
    exp1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h32, 8'h39, 8'h42, 8'h31, 8'h0D};
    reset = 1'b1; ready = 1'b0; pv36 = 1'b0; pv8 = 1'b0; pkt36 = '0; pkt8 = '0;
    repeat (3) tick();
    chk("rst_strobe", 32'(stb36), 32'd0);
    chk("rst_byte",   32'(byte36), 32'h00);
    chk("rst_busy",   32'(busy36), 32'd0);
    chk("rst_drop",   32'(drop36), 32'd0);
    chk("rst_busy8",  32'(busy8), 32'd0);
    reset = 1'b0;
    tick();

    // Directed frame "123456789" + "29B1" + CR, full throughput.
    ready = 1'b1;
    for (int i = 0; i < 14; i++) q36.push_back(exp1[i]);
    start36(36'h123456789);
    chk("lat_strobe", 32'(stb36), 32'd1);
    chk("lat_busy",   32'(busy36), 32'd1);
    chk("lat_byte",   32'(byte36), 32'h31);
    repeat (14) tick();
    chk("f1_end_busy",   32'(busy36), 32'd0);
    chk("f1_end_strobe", 32'(stb36), 32'd0);

    // Back-to-back load, with rejected loads mid-frame and on the final accept.
    push_frame(36'hABCDEF012, 9, 1'b0);
    start36(36'hABCDEF012);
    chk("b2b_strobe", 32'(stb36), 32'd1);
    chk("b2b_byte",   32'(byte36), 32'h41);
    for (int k = 1; k <= 14; k++) begin
      pv36  = (k == 3) || (k == 5) || (k == 7) || (k == 14);
      pkt36 = 36'h5A5A5A5A5 ^ 36'(k);
      tick();
    end
    pv36 = 1'b0;
    chk("drop_count", 32'(drop36), 32'd4);
    chk("drop_busy",  32'(busy36), 32'd0);

    // Reset while the third data character is stalled.
    q36.push_back(8'h46);
    q36.push_back(8'h45);
    start36(36'hFEDCBA987);
    tick();
    tick();
    ready = 1'b0;
    tick();
    chk("stall_byte", 32'(byte36), 32'h44);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_strobe", 32'(stb36), 32'd0);
    chk("abort_busy",   32'(busy36), 32'd0);
    chk("abort_drop",   32'(drop36), 32'd0);
    ready = 1'b1;
    push_frame(36'h0F1E2D3C4, 9, 1'b0);
    start36(36'h0F1E2D3C4);
    repeat (14) tick();
    chk("fresh_end_busy", 32'(busy36), 32'd0);

    // Reset and load in the same cycle: nothing loaded.
    reset = 1'b1; pv36 = 1'b1; pkt36 = 36'h111111111;
    tick();
    reset = 1'b0; pv36 = 1'b0;
    chk("rst_pv_busy", 32'(busy36), 32'd0);
    chk("rst_pv_drop", 32'(drop36), 32'd0);

    // Saturation of the drop counter during a long stall.
    ready = 1'b0;
    push_frame(36'h987654321, 9, 1'b0);
    start36(36'h987654321);
    pv36 = 1'b1;
    repeat (65534) tick();
    chk("drop_fffe", 32'(drop36), 32'h0000FFFE);
    repeat (6) tick();
    pv36 = 1'b0;
    chk("drop_sat", 32'(drop36), 32'h0000FFFF);
    ready = 1'b1;
    repeat (15) tick();
    chk("sat_end_busy", 32'(busy36), 32'd0);

    // 8-bit instance with a randomly stalling transmitter.
    ready = 1'b0;
    push_frame({28'h0, 8'hAF}, 2, 1'b1);
    pkt8 = 8'hAF; pv8 = 1'b1;
    tick();
    pv8 = 1'b0;
    chk("p8_first", 32'(byte8), 32'h41);
    for (int k = 0; k < 400 && busy8; k++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("p8_done", 32'(busy8), 32'd0);

    ready = 1'b1;
    repeat (3) tick();
    chk("q36_drained", 32'(q36.size()), 32'd0);
    chk("q8_drained",  32'(q8.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
